md_sched: RTL and testbench
===========================

# md_sched

Scheduler for the multiply/divide unit (HI/LO) of the five-stage MIPS pipeline. It accepts mult/multu/div/divu and mthi/mtlo from the E stage, models a fixed multi-cycle latency with a down-counter, commits results to HI/LO on completion, and raises the D-stage stall that freezes the F/D registers while any HI/LO-touching instruction would collide with an operation in flight. It sits beside the E-stage ALU; `hi`/`lo` feed the mfhi/mflo result path toward the M and W pipeline registers.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- startE  in  1  E-stage instruction is mult/multu/div/divu, valid this cycle
- opE  in  2  00 mult, 01 multu, 10 div, 11 divu
- srcAE  in  32  rs operand (forwarded)
- srcBE  in  32  rt operand (forwarded)
- mtE  in  2  bit0 mthi, bit1 mtlo; writes srcAE
- mdUseD  in  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- busy  out  1  operation in flight
- stallD  out  1  freeze PC and F/D register, bubble into D/E

## Operation
- State: IDLE, RUN. Counter `cnt` (4 bits at defaults, sized to max cycles), pending registers `phi`, `plo`.
- IDLE, startE=1: compute result from srcAE/srcBE/opE, latch into phi/plo, load cnt = MULT_CYCLES or DIV_CYCLES, go RUN.
- IDLE, startE=0, mtE≠0: write srcAE to HI (bit0) and/or LO (bit1) at the edge.
- RUN: cnt decrements each cycle; at cnt==1 the edge writes phi→hi, plo→lo, returns to IDLE.
- mult: signed 64-bit product, HI = [63:32], LO = [31:0]; multu unsigned.
- div: LO = signed quotient truncated toward zero, HI = remainder with dividend's sign; divu unsigned.
- Divide by zero: LO = 32'hFFFF_FFFF, HI = srcAE. div of 0x8000_0000 by −1: LO = 0x8000_0000, HI = 0.
- busy = (state == RUN).
- stallD = mdUseD & (startE | busy). Combinational.
- startE or mtE while busy: ignored, HI/LO and counter unchanged (protocol violation; bench asserts it never occurs).
- startE and mtE together: start wins, mt ignored.

## Timing
- Reset: hi=0, lo=0, busy=0, stallD=mdUseD&startE (no registered contribution), state IDLE, cnt=0, phi/plo=0.
- Reset during RUN: abort, nothing committed, values above on next cycle.
- startE sampled at edge k → busy=1 during cycles k+1 .. k+N; hi/lo show new result from cycle k+N+1... precisely: written at edge k+N, visible in cycle after it; busy low in that same cycle.
- Back-to-back: a new startE is legal in the first cycle busy=0.
- mtE at edge k → hi/lo updated in cycle k+1 (latency 1).
- mfhi/mflo are never issued while busy (held by stallD), so hi/lo outputs are read only when stable.

## Structure
- Package `md_pkg`: opcode encoding constants (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), MT_HI/MT_LO bit indices, default cycle counts.
- One sub-module `md_calc`: purely combinational, op + two operands → 64-bit {hi, lo}, including the divide-by-zero and overflow rules. md_sched holds FSM, counter, pending and architectural registers.

## Test plan
- Reset, then mult srcA=0xFFFF_FFFE (−2), srcB=3 → busy 5 cycles; then hi=0xFFFF_FFFF, lo=0xFFFF_FFFA.
- multu srcA=0xFFFF_FFFF, srcB=2 → after 5 cycles hi=1, lo=0xFFFF_FFFE; mdUseD=1 throughout busy → stallD=1 each cycle, 0 after.
- div srcA=−7, srcB=2 → after 10 cycles lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; divu 7/0 → lo=0xFFFF_FFFF, hi=7.
- mtE=2'b01 srcA=0x1234 then mtE=2'b10 srcA=0x5678 → hi=0x1234, lo=0x5678, one cycle each, busy stays 0.
- div started, reset asserted at busy cycle 4 → next cycle busy=0, hi=lo=0; no later commit.
- startE with mdUseD=1, mdUseD=0 → stallD 1 then 0; back-to-back mult issued in first non-busy cycle → second result overwrites first exactly 5 cycles later.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings for the HI/LO multiply/divide scheduler.
package md_pkg;

    // opE encoding; bit 1 set selects the divider.
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Bit positions inside mtE.
    localparam int MT_HI = 0;
    localparam int MT_LO = 1;

    // Default busy lengths of the modelled iterative units.
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Counter width able to hold the larger of the two busy lengths.
    function automatic int md_cnt_width(input int mult_cycles, input int div_cycles);
        int m;
        m = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath: op + operands -> {hi, lo}.
// Divide by zero gives lo = all ones, hi = dividend; the signed
// 0x8000_0000 / -1 overflow gives lo = 0x8000_0000, hi = 0.
module md_calc
    import md_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res
);

    logic signed [63:0] a_s64;
    logic signed [63:0] b_s64;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        b_nz;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;
    logic               div_zero;
    logic               div_ovf;

    // Compute every candidate result, then select by opcode and corner case.
    always_comb begin
        a_s64    = {{32{a[31]}}, a};
        b_s64    = {{32{b[31]}}, b};
        prod_s   = a_s64 * b_s64;
        prod_u   = {32'd0, a} * {32'd0, b};
        div_zero = (b == 32'd0);
        div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        // Divisor forced non-zero so the dividers never see a zero.
        b_nz     = div_zero ? 32'd1 : b;
        a_s      = a;
        b_s      = b_nz;
        quo_s    = a_s / b_s;
        rem_s    = a_s % b_s;
        quo_u    = a / b_nz;
        rem_u    = a % b_nz;
        res      = '0;
        case (op)
            MD_MULT:  res = prod_s;
            MD_MULTU: res = prod_u;
            MD_DIV: begin
                if (div_zero)     res = {a, 32'hFFFF_FFFF};
                else if (div_ovf) res = {32'h0000_0000, 32'h8000_0000};
                else              res = {rem_s, quo_s};
            end
            MD_DIVU: begin
                if (div_zero) res = {a, 32'hFFFF_FFFF};
                else          res = {rem_u, quo_u};
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// HI/LO scheduler: latches the mult/div result at issue, counts down a
// fixed latency, then commits it; handles mthi/mtlo and the D-stage stall.
//
// Handshake: startE is a one-cycle issue pulse accepted only while busy=0;
// the unit is then busy for exactly N cycles and hi/lo show the result in
// the first cycle busy is low again, which is also the first cycle a new
// startE or mtE may be presented. startE/mtE while busy are ignored.
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startE,
    input  logic [1:0]  opE,
    input  logic [31:0] srcAE,
    input  logic [31:0] srcBE,
    input  logic [1:0]  mtE,
    input  logic        mdUseD,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stallD
);

    localparam int CNT_W = md_cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_e        state;
    md_state_e        state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [31:0]      phi;
    logic [31:0]      phi_n;
    logic [31:0]      plo;
    logic [31:0]      plo_n;
    logic [31:0]      hi_n;
    logic [31:0]      lo_n;
    logic [63:0]      calc_res;

    md_calc u_calc (
        .op  (opE),
        .a   (srcAE),
        .b   (srcBE),
        .res (calc_res)
    );

    // State, counter, pending and architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            phi   <= '0;
            plo   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            phi   <= phi_n;
            plo   <= plo_n;
            hi    <= hi_n;
            lo    <= lo_n;
        end
    end

    // Next-state: issue or mt-write in IDLE, count down and commit in RUN.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        phi_n   = phi;
        plo_n   = plo;
        hi_n    = hi;
        lo_n    = lo;
        case (state)
            ST_IDLE: begin
                if (startE) begin
                    // Start takes priority over a simultaneous mthi/mtlo.
                    phi_n   = calc_res[63:32];
                    plo_n   = calc_res[31:0];
                    cnt_n   = opE[1] ? CNT_DIV : CNT_MULT;
                    state_n = ST_RUN;
                end else begin
                    if (mtE[MT_HI]) hi_n = srcAE;
                    if (mtE[MT_LO]) lo_n = srcAE;
                end
            end
            ST_RUN: begin
                if (cnt == CNT_ONE) begin
                    hi_n    = phi;
                    lo_n    = plo;
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Stall any HI/LO user in D while an operation is issuing or in flight.
    always_comb begin
        busy   = (state == ST_RUN);
        stallD = mdUseD & (startE | busy);
    end

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: table of mult/div vectors plus hand-written
// sequences for mthi/mtlo, start+mt priority, reset abort and back-to-back.
module tb_md_sched;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic        startE;
    logic [1:0]  opE;
    logic [31:0] srcAE;
    logic [31:0] srcBE;
    logic [1:0]  mtE;
    logic        mdUseD;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stallD;

    int tests  = 0;
    int errors = 0;

    logic [63:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        use_d;
        int          n;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    md_sched dut (
        .clk    (clk),
        .reset  (reset),
        .startE (startE),
        .opE    (opE),
        .srcAE  (srcAE),
        .srcBE  (srcBE),
        .mtE    (mtE),
        .mdUseD (mdUseD),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .stallD (stallD)
    );

    // Clock and bounded run time.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1);
    end

    // Protocol monitor: the bench must never issue while the unit is busy.
    always @(posedge clk) begin
        if (!reset && busy && (startE || mtE != 2'b00)) begin
            errors++;
            $display("FAIL protocol: issue while busy, got startE=%0b mtE=%0b required none", startE, mtE);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Issue one op at a negedge, follow it to completion and check it.
    // Returns on negedge+1 of the first non-busy cycle.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic use_d, input logic [1:0] mt,
                          input int n, input logic [31:0] eh, input logic [31:0] el);
        int cycles;
        logic [63:0] exp;
        exp_q.push_back({eh, el});
        startE = 1'b1;
        opE    = op;
        srcAE  = a;
        srcBE  = b;
        mtE    = mt;
        mdUseD = use_d;
        #1;
        chk({name, " stall_issue"}, {63'd0, stallD}, {63'd0, use_d});
        chk({name, " busy_issue"}, {63'd0, busy}, 64'd0);
        @(negedge clk);
        startE = 1'b0;
        mtE    = 2'b00;
        #1;
        cycles = 0;
        while (busy && cycles < 40) begin
            if (use_d) chk({name, " stall_busy"}, {63'd0, stallD}, 64'd1);
            cycles++;
            @(negedge clk);
            #1;
        end
        exp = exp_q.pop_front();
        chk({name, " busy_len"}, 64'(cycles), 64'(n));
        chk({name, " busy_end"}, {63'd0, busy}, 64'd0);
        chk({name, " stall_end"}, {63'd0, stallD}, 64'd0);
        chk({name, " hi"}, {32'd0, hi}, {32'd0, exp[63:32]});
        chk({name, " lo"}, {32'd0, lo}, {32'd0, exp[31:0]});
    endtask

    initial begin
        // Hand-computed results.
        vecs[0] = '{MD_MULT,  32'hFFFF_FFFE, 32'd3,        1'b0, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'd2,        1'b1, 5,  32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{MD_DIVU,  32'd7,         32'd0,        1'b0, 10, 32'h0000_0007, 32'hFFFF_FFFF};
        vecs[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 1'b1, 10, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[6] = '{MD_DIVU,  32'hFFFF_FFFF, 32'd10,       1'b0, 10, 32'h0000_0005, 32'h1999_9999};
        vecs[7] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 1'b1, 5,  32'h4000_0000, 32'h0000_0000};
        vecs[8] = '{MD_DIV,   32'hFFFF_FFFB, 32'd0,        1'b0, 10, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[9] = '{MD_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b1, 5,  32'h0000_0001, 32'h0000_0000};

        reset  = 1'b1;
        startE = 1'b0;
        opE    = 2'b00;
        srcAE  = '0;
        srcBE  = '0;
        mtE    = 2'b00;
        mdUseD = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state; stallD only sees startE while resetting.
        chk("reset hi", {32'd0, hi}, 64'd0);
        chk("reset lo", {32'd0, lo}, 64'd0);
        chk("reset busy", {63'd0, busy}, 64'd0);
        startE = 1'b1;
        mdUseD = 1'b1;
        #1;
        chk("reset stall", {63'd0, stallD}, 64'd1);
        @(negedge clk);
        startE = 1'b0;
        mdUseD = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        chk("reset no_start", {63'd0, busy}, 64'd0);

        // Table of single operations, issued back to back.
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].use_d,
                   2'b00, vecs[i].n, vecs[i].exp_hi, vecs[i].exp_lo);
        end

        // mthi then mtlo, one cycle each.
        mdUseD = 1'b1;
        mtE    = 2'b01;
        srcAE  = 32'h0000_1234;
        #1;
        chk("mt stall", {63'd0, stallD}, 64'd0);
        @(negedge clk);
        chk("mthi hi", {32'd0, hi}, 64'h1234);
        chk("mthi lo_kept", {32'd0, lo}, 64'h0);
        chk("mthi busy", {63'd0, busy}, 64'd0);
        mtE   = 2'b10;
        srcAE = 32'h0000_5678;
        @(negedge clk);
        mtE = 2'b00;
        chk("mtlo lo", {32'd0, lo}, 64'h5678);
        chk("mtlo hi_kept", {32'd0, hi}, 64'h1234);
        chk("mtlo busy", {63'd0, busy}, 64'd0);

        // startE together with mtE: start wins, mt ignored.
        startE = 1'b1;
        opE    = MD_MULT;
        srcAE  = 32'd2;
        srcBE  = 32'd3;
        mtE    = 2'b11;
        @(negedge clk);
        startE = 1'b0;
        mtE    = 2'b00;
        chk("start_mt hi_kept", {32'd0, hi}, 64'h1234);
        chk("start_mt lo_kept", {32'd0, lo}, 64'h5678);
        chk("start_mt busy", {63'd0, busy}, 64'd1);
        repeat (5) @(negedge clk);
        chk("start_mt hi", {32'd0, hi}, 64'd0);
        chk("start_mt lo", {32'd0, lo}, 64'd6);
        chk("start_mt done", {63'd0, busy}, 64'd0);

        // Back-to-back mults through the full-check path.
        run_op("b2b_a", MD_MULT, 32'd100, 32'd200, 1'b1, 2'b00, 5, 32'd0, 32'd20000);
        run_op("b2b_b", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'b00, 5,
               32'hFFFF_FFFE, 32'h0000_0001);

        // Reset during a divide: abort, nothing committed later.
        startE = 1'b1;
        opE    = MD_DIV;
        srcAE  = 32'd100;
        srcBE  = 32'd7;
        mdUseD = 1'b0;
        @(negedge clk);
        startE = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort busy4", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", {63'd0, busy}, 64'd0);
        chk("abort hi", {32'd0, hi}, 64'd0);
        chk("abort lo", {32'd0, lo}, 64'd0);
        repeat (12) @(negedge clk);
        chk("abort late_busy", {63'd0, busy}, 64'd0);
        chk("abort late_hi", {32'd0, hi}, 64'd0);
        chk("abort late_lo", {32'd0, lo}, 64'd0);

        // stallD is combinational on mdUseD with startE.
        startE = 1'b1;
        opE    = MD_MULT;
        srcAE  = 32'd1;
        srcBE  = 32'd1;
        mdUseD = 1'b1;
        #1;
        chk("stall use1", {63'd0, stallD}, 64'd1);
        mdUseD = 1'b0;
        #1;
        chk("stall use0", {63'd0, stallD}, 64'd0);
        @(negedge clk);
        startE = 1'b0;
        repeat (5) @(negedge clk);
        chk("stall_op lo", {32'd0, lo}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
